// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types for the bit feeder and the display stage.
// Both stages decode the same 800x525 raster, so every window boundary lives here.
package vga_timing_pkg;

    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int H_ACT_START = 143;
    localparam int H_ACT_W     = 320;
    localparam int V_ACT_START = 36;
    localparam int V_ACT_H     = 160;
    localparam int WORD_W      = 16;

    localparam int H_W            = 10;
    localparam int V_W            = 10;
    localparam int BIT_W          = 4;
    localparam int WORD_IDX_W     = 5;
    localparam int WORDS_PER_LINE = H_ACT_W / WORD_W;

    typedef logic [H_W-1:0]        h_cnt_t;
    typedef logic [V_W-1:0]        v_cnt_t;
    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [BIT_W-1:0]      bit_idx_t;
    typedef logic [WORD_IDX_W-1:0] word_idx_t;

    localparam h_cnt_t H_MAX       = h_cnt_t'(H_TOTAL - 1);
    localparam v_cnt_t V_MAX       = v_cnt_t'(V_TOTAL - 1);
    localparam h_cnt_t H_ACT_FIRST = h_cnt_t'(H_ACT_START);
    localparam h_cnt_t H_ACT_LAST  = h_cnt_t'(H_ACT_START + H_ACT_W - 1);
    localparam v_cnt_t V_ACT_FIRST = v_cnt_t'(V_ACT_START);
    localparam v_cnt_t V_ACT_LAST  = v_cnt_t'(V_ACT_START + V_ACT_H - 1);

    // First word: decide at 140, strobe at 141, data valid and loaded at 142.
    localparam h_cnt_t H_FETCH0 = h_cnt_t'(H_ACT_START - 3);
    localparam h_cnt_t H_LOAD0  = h_cnt_t'(H_ACT_START - 1);

    localparam bit_idx_t  BIT_FETCH = bit_idx_t'(WORD_W - 3);
    localparam bit_idx_t  BIT_LAST  = bit_idx_t'(WORD_W - 1);
    localparam word_idx_t WORD_LAST = word_idx_t'(WORDS_PER_LINE - 1);

    function automatic logic in_span(input logic [9:0] x, input logic [9:0] lo,
                                     input logic [9:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// Free-running 800x525 raster counters with active-window and frame-wrap decode.
// The display stage instantiates the same block so both stay in lockstep.
module vga_timing_cnt
    import vga_timing_pkg::*;
(
    input  logic   clk_vga,
    input  logic   rst_mix,
    input  logic   start,
    output h_cnt_t h_cnt,
    output logic   active_line,
    output logic   active_pix,
    output logic   frame_start
);

    v_cnt_t v_cnt;

    // v_cnt follows h_cnt==799 even while start is low, matching the display stage.
    always_ff @(posedge clk_vga or negedge rst_mix) begin
        if (!rst_mix) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= start && (h_cnt == H_MAX) && (v_cnt == V_MAX);
            if (start) begin
                h_cnt <= (h_cnt == H_MAX) ? '0 : h_cnt + 1'b1;
            end
            if (h_cnt == H_MAX) begin
                v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
            end
        end
    end

    assign active_line = in_span(v_cnt, V_ACT_FIRST, V_ACT_LAST);
    assign active_pix  = active_line && in_span(h_cnt, H_ACT_FIRST, H_ACT_LAST);

endmodule

// File: rtl/vga_bit_feeder.sv
// Drains 16-bit FIFO words and shifts them MSB-first onto etch, one bit per active pixel.
// Starved fetches substitute a black word and are counted; the fetch schedule never slips.
module vga_bit_feeder
    import vga_timing_pkg::*;
(
    input  logic        clk_vga,
    input  logic        rst_mix,
    input  logic        start,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        etch,
    output logic        frame_start,
    output logic        underflow,
    output logic [7:0]  underflow_cnt
);

    h_cnt_t    h_cnt;
    logic      active_line;
    logic      active_pix;
    word_t     sr;
    word_t     word_buf;
    logic      pend;
    bit_idx_t  bit_idx;
    word_idx_t word_idx;

    logic  fetch_due;
    logic  shift_step;
    logic  load_word;
    word_t load_src;

    vga_timing_cnt u_timing (
        .clk_vga     (clk_vga),
        .rst_mix     (rst_mix),
        .start       (start),
        .h_cnt       (h_cnt),
        .active_line (active_line),
        .active_pix  (active_pix),
        .frame_start (frame_start)
    );

    assign shift_step = start && active_pix;

    assign fetch_due = start && active_line &&
                       ((h_cnt == H_FETCH0) ||
                        (active_pix && (bit_idx == BIT_FETCH) && (word_idx != WORD_LAST)));

    assign load_word = (start && active_line && (h_cnt == H_LOAD0)) ||
                       (shift_step && (bit_idx == BIT_LAST) && (word_idx != WORD_LAST));

    // Data arriving while paused is parked in word_buf so sr stays frozen until resume.
    assign load_src = pend ? fifo_dout : word_buf;

    assign etch = active_pix && sr[WORD_W-1];

    always_ff @(posedge clk_vga or negedge rst_mix) begin
        if (!rst_mix) begin
            fifo_rd_en    <= 1'b0;
            pend          <= 1'b0;
            word_buf      <= '0;
            sr            <= '0;
            bit_idx       <= '0;
            word_idx      <= '0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            fifo_rd_en <= fetch_due && !fifo_empty;
            pend       <= fifo_rd_en;

            if (fetch_due && fifo_empty) begin
                word_buf  <= '0;
                underflow <= 1'b1;
                if (underflow_cnt != 8'hFF) begin
                    underflow_cnt <= underflow_cnt + 8'd1;
                end
            end else if (pend) begin
                word_buf <= fifo_dout;
            end

            if (load_word) begin
                sr <= load_src;
            end else if (shift_step) begin
                sr <= {sr[WORD_W-2:0], 1'b0};
            end

            if (shift_step) begin
                bit_idx <= bit_idx + 1'b1;
                if (bit_idx == BIT_LAST) begin
                    word_idx <= (word_idx == WORD_LAST) ? '0 : word_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_bit_feeder.sv
// Directed bench for vga_bit_feeder: a raster/slot model predicts every output each cycle,
// with literal expectations at hand-picked pixels.
module tb_vga_bit_feeder;

    logic        clk_vga = 1'b0;
    logic        rst_mix;
    logic        start;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        etch;
    logic        frame_start;
    logic        underflow;
    logic [7:0]  underflow_cnt;

    vga_bit_feeder dut (
        .clk_vga       (clk_vga),
        .rst_mix       (rst_mix),
        .start         (start),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .etch          (etch),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    always #20 clk_vga = ~clk_vga;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO contents and the two independent cursors into them
    logic [15:0] word_src[$];
    int fifo_ptr;
    int model_ptr;
    int rd_total;

    // raster model
    int hm, vm;
    logic [15:0] cur_word;
    int starve_raw;
    int plan;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", name, got, exp, hm, vm);
        end
    endtask

    function automatic bit starved(input int v, input int n);
        if (plan == 1) return (v == 40 && n == 5) || (v >= 41 && v <= 53);
        if (plan == 2) return (v == 60 && n == 0);
        return 1'b0;
    endfunction

    function automatic bit force_window(input int h, input int v);
        if (plan == 1) return (v == 40 && h >= 210 && h <= 230) || (v >= 41 && v <= 53);
        if (plan == 2) return (v == 60 && h >= 130 && h <= 141);
        return 1'b0;
    endfunction

    // Word slot whose read strobe belongs at pixel h, or -1.
    function automatic int fetch_slot(input int h);
        if (h == 141) return 0;
        if (h >= 157 && h <= 445 && ((h - 157) % 16) == 0) return (h - 157) / 16 + 1;
        return -1;
    endfunction

    task automatic model_reset();
        hm = 0; vm = 0; cur_word = '0; starve_raw = 0;
        model_ptr = 0; fifo_ptr = word_src.size(); rd_total = 0;
        fifo_dout = '0;
    endtask

    task automatic update_empty();
        fifo_empty = force_window(hm, vm) || (fifo_ptr >= word_src.size());
    endtask

    // One clock: advance the model, compare every output, service the FIFO.
    task automatic tick();
        bit adv;
        int ph, pv, n, k;
        bit act_line, act, exp_rd, exp_fs, exp_etch;
        adv = start && rst_mix;
        ph = hm; pv = vm;
        @(negedge clk_vga);
        exp_rd = 0; exp_fs = 0; exp_etch = 0;
        if (!rst_mix) begin
            model_reset();
        end else begin
            if (adv) hm = (hm == 799) ? 0 : hm + 1;
            if (ph == 799) vm = (vm == 524) ? 0 : vm + 1;
            exp_fs = adv && ph == 799 && pv == 524;
            act_line = vm >= 36 && vm <= 195;
            act = act_line && hm >= 143 && hm <= 462;
            if (adv && act_line) begin
                n = fetch_slot(hm);
                if (n >= 0) begin
                    if (starved(vm, n)) starve_raw++;
                    else exp_rd = 1;
                end
            end
            if (act) begin
                k = (hm - 143) % 16;
                if (adv && k == 0) begin
                    n = (hm - 143) / 16;
                    if (starved(vm, n)) cur_word = '0;
                    else if (model_ptr < word_src.size()) cur_word = word_src[model_ptr++];
                    else cur_word = 'x;
                end
                exp_etch = cur_word[15-k];
            end
        end
        check("etch", etch, exp_etch);
        check("rd_en", fifo_rd_en, exp_rd);
        check("frame_start", frame_start, exp_fs);
        check("underflow", underflow, starve_raw > 0);
        check("underflow_cnt", underflow_cnt, (starve_raw > 255) ? 255 : starve_raw);
        if (fifo_rd_en) begin
            rd_total++;
            if (fifo_ptr < word_src.size()) fifo_dout = word_src[fifo_ptr++];
            else check("read_while_empty", 1, 0);
        end
        update_empty();
    endtask

    task automatic run_to(input int h, input int v);
        int i;
        for (i = 0; i < 450000 && !(hm == h && vm == v); i++) tick();
        if (!(hm == h && vm == v)) check("reach_timeout", 0, 1);
    endtask

    // Fast-forward: park h at 799 with start low so v steps every clock.
    task automatic goto_line(input int l);
        int i;
        run_to(799, vm);
        start = 0;
        for (i = 0; i < 530 && vm != l - 1; i++) tick();
        start = 1;
        tick();
        check("goto_line", vm, l);
    endtask

    task automatic reset_dut();
        rst_mix = 0; start = 0; plan = 0;
        word_src.delete();
        #1;
        model_reset();
        update_empty();
        repeat (2) tick();
        rst_mix = 1;
    endtask

    initial begin
        rst_mix = 0; start = 0; plan = 0; fifo_dout = '0; fifo_empty = 1;
        model_reset();
        repeat (3) tick();
        check("rst_etch", etch, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underflow", underflow, 0);
        check("rst_cnt", underflow_cnt, 0);

        // Word boundary, A5A5 pattern, then starvation
        reset_dut();
        word_src.push_back(16'h8001);
        word_src.push_back(16'h0001);
        for (int i = 0; i < 198; i++) word_src.push_back(16'hA5A5);
        fifo_ptr = 0; plan = 1; start = 1;
        update_empty();
        goto_line(35);
        run_to(143, 36); check("w0_msb", etch, 1);
        run_to(144, 36); check("w0_b1", etch, 0);
        run_to(158, 36); check("w0_lsb", etch, 1);
        run_to(159, 36); check("w1_msb", etch, 0);
        run_to(174, 36); check("w1_lsb", etch, 1);
        run_to(175, 36); check("a5_b0", etch, 1);
        run_to(176, 36); check("a5_b1", etch, 0);
        run_to(462, 36); check("last_px", etch, 1);
        run_to(463, 36); check("after_act", etch, 0);
        run_to(0, 38);   check("reads_2_lines", rd_total, 40);
        run_to(223, 40); check("starve_w5", etch, 0);
        run_to(239, 40); check("after_starve", etch, 1);
        check("uf_flag", underflow, 1);
        check("uf_cnt1", underflow_cnt, 1);
        run_to(0, 41);   check("reads_line40", rd_total, 99);
        run_to(0, 54);   check("uf_sat", underflow_cnt, 255);
        check("reads_starved", rd_total, 99);
        run_to(200, 54);

        // Pauses before a strobe, on a strobe and on a load pixel
        reset_dut();
        for (int p = 0; p < 100; p++) word_src.push_back(16'(32'h1234 ^ (p * 32'h0BAD)));
        fifo_ptr = 0; start = 1;
        update_empty();
        goto_line(50);
        run_to(300, 50);
        start = 0; repeat (50) tick();
        start = 1; tick();
        start = 0; repeat (10) tick();
        start = 1; run_to(302, 50);
        start = 0; repeat (5) tick();
        check("paused_w9_lsb", etch, 1);
        start = 1;
        run_to(0, 51); check("reads_paused_line", rd_total, 20);

        // Frame wrap, then async reset mid-line
        reset_dut();
        for (int i = 0; i < 100; i++) word_src.push_back(16'hFFFF);
        fifo_ptr = 0; plan = 2; start = 1;
        update_empty();
        run_to(799, 0);
        start = 0;
        for (int i = 0; i < 530 && vm != 524; i++) tick();
        start = 1; tick();
        check("wrap_fs", frame_start, 1);
        tick();
        check("wrap_fs_end", frame_start, 0);
        goto_line(60);
        run_to(150, 60); check("starved_w0", etch, 0);
        run_to(200, 60); check("pre_rst_etch", etch, 1);
        check("pre_rst_uf", underflow_cnt, 1);
        #5 rst_mix = 0;
        #1;
        check("arst_etch", etch, 0);
        check("arst_rd_en", fifo_rd_en, 0);
        check("arst_fs", frame_start, 0);
        check("arst_uf", underflow, 0);
        check("arst_cnt", underflow_cnt, 0);
        start = 0;
        repeat (3) tick();
        rst_mix = 1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
